// File: rtl/diff_counter_pkg.sv
// Shared definitions for the up/down sign-magnitude counter and its button conditioners.
package diff_counter_pkg;

  localparam int unsigned MAG_W    = 4;
  localparam logic        SIGN_NEG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/diff_counter_btn_conditioner.sv
// Raw push-button to step pulses: 2-FF synchroniser, debouncer, press/hold/auto-repeat FSM.
module btn_conditioner
  import diff_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step
);

  localparam int unsigned MAX_CYC = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPT_LD  = CNT_W'(REPEAT_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic             level_q;
  logic             armed_q;
  logic [CNT_W-1:0] db_cnt_q;

  step_state_e      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             step_q, step_d;

  // fill_q marks when sync_q holds real samples rather than reset zeros
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else if (sync_q[1] == level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_q  <= ~level_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + CNT_W'(1);
    end
  end

  // A button held through reset must be seen released before it can step again
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
    end else if (fill_q[1] && !sync_q[1] && !level_q) begin
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level_q && armed_q) begin
          step_d  = 1'b1;
          state_d = ST_HOLD;
          timer_d = HOLD_LD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!level_q) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          step_d  = 1'b1;
          state_d = ST_REPEAT;
          timer_d = REPT_LD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign step = step_q;

endmodule

// File: rtl/diff_counter.sv
// Saturating sign-magnitude up/down counter driven by two debounced, auto-repeating buttons.
module diff_counter
  import diff_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter int unsigned MAX_MAG         = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             clear,
  output logic [MAG_W-1:0] diff,
  output logic             sinal,
  output logic             at_limit,
  output logic             changed
);

  localparam logic [MAG_W-1:0] MAX_M = MAG_W'(MAX_MAG);
  localparam logic [MAG_W-1:0] ONE_M = MAG_W'(1);

  logic             step_up, step_down;
  logic [MAG_W-1:0] diff_q, diff_d;
  logic             sinal_q, sinal_d;
  logic             at_limit_q, at_limit_d;
  logic             changed_q, changed_d;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_up (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_up),
    .step (step_up)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_down (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_down),
    .step (step_down)
  );

  // Zero is always stored with a positive sign, so crossing zero flips the sign explicitly
  always_comb begin
    diff_d  = diff_q;
    sinal_d = sinal_q;
    if (clear) begin
      diff_d  = '0;
      sinal_d = ~SIGN_NEG;
    end else if (step_up && !step_down) begin
      if (sinal_q == SIGN_NEG && diff_q == ONE_M) begin
        diff_d  = '0;
        sinal_d = ~SIGN_NEG;
      end else if (sinal_q == SIGN_NEG) begin
        diff_d = diff_q - ONE_M;
      end else if (diff_q < MAX_M) begin
        diff_d = diff_q + ONE_M;
      end
    end else if (step_down && !step_up) begin
      if (sinal_q != SIGN_NEG && diff_q == '0) begin
        diff_d  = ONE_M;
        sinal_d = SIGN_NEG;
      end else if (sinal_q != SIGN_NEG) begin
        diff_d = diff_q - ONE_M;
      end else if (diff_q < MAX_M) begin
        diff_d = diff_q + ONE_M;
      end
    end
    changed_d  = (diff_d != diff_q) || (sinal_d != sinal_q);
    at_limit_d = (diff_d == MAX_M);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      diff_q     <= '0;
      sinal_q    <= ~SIGN_NEG;
      at_limit_q <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      diff_q     <= diff_d;
      sinal_q    <= sinal_d;
      at_limit_q <= at_limit_d;
      changed_q  <= changed_d;
    end
  end

  assign diff     = diff_q;
  assign sinal    = sinal_q;
  assign at_limit = at_limit_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_diff_counter.sv
// Self-checking bench for diff_counter: directed scenarios plus randomized presses vs. an integer model.
module tb_diff_counter;

  localparam int unsigned D = 4;
  localparam int unsigned H = 20;
  localparam int unsigned R = 8;
  localparam int MAXV = 15;
  localparam int DI = 4;
  localparam int HI = 20;
  localparam int RI = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] diff;
  logic       sinal;
  logic       at_limit;
  logic       changed;

  int checks = 0;
  int errors = 0;
  int changed_cnt = 0;
  int negzero_cnt = 0;
  int model_v = 0;

  diff_counter #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .MAX_MAG        (15)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .clear   (clear),
    .diff    (diff),
    .sinal   (sinal),
    .at_limit(at_limit),
    .changed (changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (changed === 1'b1) changed_cnt++;
    if (sinal === 1'b1 && diff == 4'd0) negzero_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Steps a clean press of len cycles yields: one at press, one after HOLD, then every REPEAT
  function automatic int steps_for(input int len);
    int n = 0;
    int k = 0;
    while (k <= len - 1) begin
      n++;
      k = (n == 1) ? HI : k + RI;
    end
    return n;
  endfunction

  function automatic int apply_step(input int v, input bit up);
    if (up) return (v < MAXV) ? v + 1 : v;
    return (v > -MAXV) ? v - 1 : v;
  endfunction

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit up, input bit dn, input int len);
    @(negedge clk);
    btn_up = up;
    btn_down = dn;
    tick(len);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(DI + 8);
  endtask

  task automatic model_press(input bit up, input int len, output int nchg);
    int nv;
    nchg = 0;
    for (int i = 0; i < steps_for(len); i++) begin
      nv = apply_step(model_v, up);
      if (nv != model_v) nchg++;
      model_v = nv;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_v = 0;
    tick(2);
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (diff !== 4'd0) begin errors++; $display("FAIL reset_diff got %0d want 0", diff); end
    checks++; if (sinal !== 1'b0) begin errors++; $display("FAIL reset_sinal got %b want 0", sinal); end
    checks++; if (at_limit !== 1'b0) begin errors++; $display("FAIL reset_at_limit got %b want 0", at_limit); end
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b want 0", changed); end
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_reset_held();
    int c0;
    @(negedge clk);
    btn_up = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_v = 0;
    c0 = changed_cnt;
    tick(60);
    checks++; if (diff !== 4'd0) begin errors++; $display("FAIL held_reset_diff got %0d want 0", diff); end
    checks++; if (changed_cnt - c0 != 0) begin errors++; $display("FAIL held_reset_changes got %0d want 0", changed_cnt - c0); end
    btn_up = 1'b0;
    tick(DI + 6);
    c0 = changed_cnt;
    press(1'b1, 1'b0, DI + 3);
    checks++; if (diff !== 4'd1 || sinal !== 1'b0) begin errors++; $display("FAIL repress_value got %0d/%b want 1/0", diff, sinal); end
    checks++; if (changed_cnt - c0 != 1) begin errors++; $display("FAIL repress_changes got %0d want 1", changed_cnt - c0); end
  endtask

  task automatic test_bounce();
    int c0;
    int t = 0;
    int n;
    do_clear();
    c0 = changed_cnt;
    while (t < 30) begin
      btn_up = 1'b1;
      n = $urandom_range(1, 2);
      tick(n);
      t += n;
      btn_up = 1'b0;
      n = $urandom_range(1, 2);
      tick(n);
      t += n;
    end
    checks++; if (changed_cnt - c0 != 0) begin errors++; $display("FAIL bounce_glitch_changes got %0d want 0", changed_cnt - c0); end
    btn_up = 1'b1;
    tick(6);
    btn_up = 1'b0;
    tick(DI + 8);
    checks++; if (diff !== 4'd1 || sinal !== 1'b0) begin errors++; $display("FAIL bounce_value got %0d/%b want 1/0", diff, sinal); end
    checks++; if (changed_cnt - c0 != 1) begin errors++; $display("FAIL bounce_changes got %0d want 1", changed_cnt - c0); end
  endtask

  task automatic test_sign_cross();
    int z0;
    do_clear();
    z0 = negzero_cnt;
    press(1'b0, 1'b1, DI + 3);
    checks++; if (diff !== 4'd1 || sinal !== 1'b1) begin errors++; $display("FAIL down_from_zero got %0d/%b want 1/1", diff, sinal); end
    press(1'b1, 1'b0, DI + 3);
    checks++; if (diff !== 4'd0 || sinal !== 1'b0) begin errors++; $display("FAIL up_to_zero got %0d/%b want 0/0", diff, sinal); end
    checks++; if (negzero_cnt != z0) begin errors++; $display("FAIL negative_zero_seen got %0d want %0d", negzero_cnt, z0); end
  endtask

  task automatic test_auto_repeat();
    int got[$];
    int exp_t[$];
    int v = 0;
    int nv;
    int off = 0;
    int n = 0;
    do_clear();
    while (DI + 4 + off <= 200) begin
      nv = apply_step(v, 1'b1);
      if (nv != v) exp_t.push_back(DI + 4 + off);
      v = nv;
      n++;
      off = (n == 1) ? HI : off + RI;
    end
    @(negedge clk);
    btn_up = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (changed === 1'b1) got.push_back(i);
    end
    btn_up = 1'b0;
    tick(DI + 8);
    model_v = v;
    checks++; if (got.size() != exp_t.size()) begin errors++; $display("FAIL repeat_count got %0d want %0d", got.size(), exp_t.size()); end
    for (int i = 0; i < exp_t.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] != exp_t[i]) begin errors++; $display("FAIL repeat_time[%0d] got %0d want %0d", i, got[i], exp_t[i]); end
    end
    checks++; if (diff !== 4'd15 || sinal !== 1'b0) begin errors++; $display("FAIL repeat_value got %0d/%b want 15/0", diff, sinal); end
    checks++; if (at_limit !== 1'b1) begin errors++; $display("FAIL repeat_at_limit got %b want 1", at_limit); end
  endtask

  task automatic test_collision();
    int c0;
    do_clear();
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, DI + 3);
    checks++; if (diff !== 4'd3 || sinal !== 1'b0) begin errors++; $display("FAIL collision_setup got %0d/%b want 3/0", diff, sinal); end
    c0 = changed_cnt;
    press(1'b1, 1'b1, DI + 3);
    checks++; if (diff !== 4'd3 || sinal !== 1'b0) begin errors++; $display("FAIL collision_value got %0d/%b want 3/0", diff, sinal); end
    checks++; if (changed_cnt - c0 != 0) begin errors++; $display("FAIL collision_changes got %0d want 0", changed_cnt - c0); end
    model_v = 3;
  endtask

  task automatic test_clear_with_step();
    int c0;
    do_clear();
    for (int i = 0; i < 7; i++) press(1'b0, 1'b1, DI + 3);
    checks++; if (diff !== 4'd7 || sinal !== 1'b1) begin errors++; $display("FAIL clear_setup got %0d/%b want 7/1", diff, sinal); end
    c0 = changed_cnt;
    @(negedge clk);
    btn_up = 1'b1;
    tick(DI + 3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    btn_up = 1'b0;
    tick(DI + 8);
    model_v = 0;
    checks++; if (diff !== 4'd0 || sinal !== 1'b0) begin errors++; $display("FAIL clear_step_value got %0d/%b want 0/0", diff, sinal); end
    checks++; if (changed_cnt - c0 != 1) begin errors++; $display("FAIL clear_step_changes got %0d want 1", changed_cnt - c0); end
  endtask

  task automatic test_random();
    int c0;
    int len;
    int nchg;
    bit up;
    do_clear();
    for (int it = 0; it < 24; it++) begin
      up = 1'($urandom_range(0, 1));
      len = $urandom_range(DI + 1, 70);
      c0 = changed_cnt;
      press(up, !up, len);
      model_press(up, len, nchg);
      tick($urandom_range(0, 5));
      checks++;
      if (diff !== 4'(abs_i(model_v)) || sinal !== (model_v < 0) || at_limit !== (abs_i(model_v) == MAXV)) begin
        errors++;
        $display("FAIL rand_value[%0d] got %0d/%b/%b want %0d/%b/%b", it, diff, sinal, at_limit,
                 abs_i(model_v), model_v < 0, abs_i(model_v) == MAXV);
      end
      checks++;
      if (changed_cnt - c0 != nchg) begin errors++; $display("FAIL rand_changes[%0d] got %0d want %0d", it, changed_cnt - c0, nchg); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_held();
    test_bounce();
    test_sign_cross();
    test_auto_repeat();
    test_collision();
    test_clear_with_step();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
